// File: rtl/csr_uart_tx.sv
// csr_uart_tx: CSR-mapped UART transmitter with integrated FIFO, runtime config and tx-done interrupt
module csr_uart_tx #(
  parameter int          DataBits     = 8,
  parameter int          FifoDepth    = 8,
  parameter int          PrescWidth   = 16,
  parameter int          DefaultPresc = 867,
  parameter logic [11:0] DataAddr     = 12'h7C0,
  parameter logic [11:0] StatusAddr   = 12'h7C1,
  parameter logic [11:0] ConfigAddr   = 12'h7C2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_enable,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_zimm,
  input  logic [31:0] rs1_data,
  input  logic [2:0]  csr_op,
  output logic [31:0] csr_out,
  output logic        tx,
  output logic        irq_out
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DataBits);
  // config keeps only the implemented fields; other bits read as zero
  localparam logic [31:0] CfgMask = 32'h000F_0000 | ((32'd1 << PrescWidth) - 32'd1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e                state_q;
  logic [31:0]           wdata, cfg_q, cfg_d, cfg_new;
  logic [DataBits-1:0]   mem_q [FifoDepth];
  logic [DataBits-1:0]   head, sh_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PrescWidth-1:0] presc_q, baud_q;
  logic [BW-1:0]         bit_q;
  logic wr_op, push, accept, pop, full, empty, busy, busy_d, tick, last_stop;
  logic ovf_q, ovf_d, irq_q, irq_d, tx_q, par_q, par_en_q, stop2_q, stop_idx_q;

  // CSR decode, FIFO bookkeeping and frame-sequencing handshakes
  always_comb begin
    wdata     = csr_op[2] ? 32'(rs1_zimm) : rs1_data;
    wr_op     = csr_enable && csr_op[1:0] != 2'b00;
    cfg_new   = csr_op[1:0] == 2'b01 ? wdata : csr_op[1:0] == 2'b10 ? cfg_q | wdata : cfg_q & ~wdata;
    cfg_d     = wr_op && csr_addr == ConfigAddr ? cfg_new & CfgMask : cfg_q;
    empty     = cnt_q == '0;
    full      = cnt_q == CW'(FifoDepth);
    busy      = state_q != IDLE;
    tick      = baud_q == '0;
    last_stop = state_q == STOP && tick && (!stop2_q || stop_idx_q);
    pop       = !empty && (state_q == IDLE || last_stop);
    busy_d    = pop || (busy && !last_stop);
    push      = csr_enable && csr_addr == DataAddr && csr_op[1:0] == 2'b01;
    accept    = push && (!full || pop);
    ovf_d     = push && !accept ? 1'b1 : wr_op && csr_addr == StatusAddr && wdata[3] ? 1'b0 : ovf_q;
    cnt_d     = cnt_q + CW'(accept) - CW'(pop);
    irq_d     = cfg_q[19] && cnt_d == '0 && !busy && !busy_d;
    head      = mem_q[rd_q];
    csr_out   = csr_addr == StatusAddr ? {16'b0, 8'(cnt_q), 4'b0, ovf_q, busy, full, empty} :
                csr_addr == ConfigAddr ? cfg_q : 32'b0;
  end

  // FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= wdata[DataBits-1:0];
  end

  // FIFO pointers, sticky overflow, configuration and interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      cfg_q <= 32'(DefaultPresc) & CfgMask;
      irq_q <= 1'b0;
    end else begin
      if (accept) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      cfg_q <= cfg_d;
      irq_q <= irq_d;
    end
  end

  // Frame FSM: config is latched at frame start so mid-frame writes only affect the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      sh_q       <= '0;
      presc_q    <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
    end else if (pop) begin
      state_q    <= START;
      tx_q       <= 1'b0;
      sh_q       <= head;
      presc_q    <= cfg_q[PrescWidth-1:0];
      baud_q     <= cfg_q[PrescWidth-1:0];
      par_en_q   <= cfg_q[17] ^ cfg_q[16];
      par_q      <= cfg_q[17] ^ (^head);
      stop2_q    <= cfg_q[18];
      stop_idx_q <= 1'b0;
    end else if (busy && !tick) begin
      baud_q <= baud_q - PrescWidth'(1);
    end else if (busy) begin
      baud_q <= presc_q;
      case (state_q)
        START: begin
          tx_q    <= sh_q[0];
          sh_q    <= sh_q >> 1;
          bit_q   <= '0;
          state_q <= DATA;
        end
        DATA: begin
          if (bit_q == BW'(DataBits - 1)) begin
            tx_q    <= par_en_q ? par_q : 1'b1;
            state_q <= par_en_q ? PARITY : STOP;
          end else begin
            tx_q  <= sh_q[0];
            sh_q  <= sh_q >> 1;
            bit_q <= bit_q + BW'(1);
          end
        end
        PARITY: begin
          tx_q    <= 1'b1;
          state_q <= STOP;
        end
        STOP: begin
          stop_idx_q <= 1'b1;
          if (last_stop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign irq_out = irq_q;
endmodule
